// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and request decoding for the dual-pointer FIFO controller.
package fifo_ctrl_pkg;

  localparam int DEF_LENGTH    = 8;
  localparam int DEF_PTR_WIDTH = 3;
  localparam int DEF_AFULL_TH  = 6;
  localparam int DEF_AEMPTY_TH = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push_ok, input logic pop_ok);
    return op_e'({pop_ok, push_ok});
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register.
// Wraps from LENGTH-1 back to 0 by explicit compare, so LENGTH need not be a power of two.
module fifo_ptr #(
  parameter int LENGTH    = fifo_ctrl_pkg::DEF_LENGTH,
  parameter int PTR_WIDTH = fifo_ctrl_pkg::DEF_PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(LENGTH - 1);
  localparam logic [PTR_WIDTH-1:0] ONE  = PTR_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + ONE;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the dual-pointer FIFO memory.
// Produces the memory strobes, pointers, occupancy, status flags and sticky error flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int LENGTH    = DEF_LENGTH,
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  output logic                 write,
  output logic [PTR_WIDTH-1:0] ptr_write,
  output logic                 read,
  output logic [PTR_WIDTH-1:0] ptr_read,
  output logic                 rd_valid,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] LEN_C    = CW'(LENGTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_next;

  // Requests are qualified against the registered flags only.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign write   = push_ok;
  assign read    = pop_ok;

  fifo_ptr #(.LENGTH(LENGTH), .PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (ptr_write)
  );

  fifo_ptr #(.LENGTH(LENGTH), .PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (ptr_read)
  );

  always_comb begin
    count_next = count;
    case (decode_op(push_ok, pop_ok))
      OP_PUSH: count_next = count + ONE_C;
      OP_POP:  count_next = count - ONE_C;
      default: count_next = count;
    endcase
  end

  // Flags are computed from count_next so they line up with the new count, not a cycle behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      count        <= count_next;
      full         <= (count_next == LEN_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);
      overflow     <= overflow | (push & full);
      underflow    <= underflow | (pop & empty);
      rd_valid     <= pop_ok;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl.
// Includes a simple registered memory model and a second instance with LENGTH=6.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0, pop = 1'b0;
  logic       write, read, rd_valid;
  logic [2:0] ptr_write, ptr_read;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  logic       push6 = 1'b0, pop6 = 1'b0;
  logic       write6, read6, rd_valid6;
  logic [2:0] ptr_write6, ptr_read6;
  logic [3:0] count6;
  logic       full6, empty6, almost_full6, almost_empty6, overflow6, underflow6;

  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic [9:0] mem [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .write(write), .ptr_write(ptr_write), .read(read), .ptr_read(ptr_read),
    .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_ctrl #(.LENGTH(6), .PTR_WIDTH(3), .AFULL_TH(5), .AEMPTY_TH(1)) dut6 (
    .clk(clk), .reset(reset), .push(push6), .pop(pop6),
    .write(write6), .ptr_write(ptr_write6), .read(read6), .ptr_read(ptr_read6),
    .rd_valid(rd_valid6), .count(count6), .full(full6), .empty(empty6),
    .almost_full(almost_full6), .almost_empty(almost_empty6),
    .overflow(overflow6), .underflow(underflow6)
  );

  // Registered memory driven by the controller strobes.
  always @(posedge clk) begin
    if (write) mem[ptr_write] <= data_in;
    if (read) data_out <= mem[ptr_read];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; push6 = 1'b0; pop6 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, ptr_write, ptr_read, rd_valid} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got cnt=%0d pw=%0d pr=%0d rv=%0b exp all 0", count, ptr_write, ptr_read, rd_valid);
    end
    checks++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      failures++;
      $display("[TB] FAIL reset_flags got %b exp 101000", {empty, full, almost_empty, almost_full, overflow, underflow});
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_cnt;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      data_in = 10'(i + 1);
      #1;
      checks++;
      if (write !== 1'b1 || ptr_write !== 3'(i)) begin
        failures++;
        $display("[TB] FAIL fill_strobe[%0d] got wr=%0b pw=%0d exp wr=1 pw=%0d", i, write, ptr_write, i);
      end
      tick();
      exp_cnt = 4'(i + 1);
      checks++;
      if (count !== exp_cnt || ptr_write !== 3'((i + 1) % 8)) begin
        failures++;
        $display("[TB] FAIL fill_count[%0d] got cnt=%0d pw=%0d exp cnt=%0d pw=%0d", i, count, ptr_write, exp_cnt, (i + 1) % 8);
      end
      checks++;
      if (almost_empty !== (exp_cnt <= 4'd2) || almost_full !== (exp_cnt >= 4'd6) ||
          full !== (exp_cnt == 4'd8) || empty !== 1'b0 || overflow !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fill_flags[%0d] got ae=%0b af=%0b f=%0b e=%0b ov=%0b at cnt=%0d", i, almost_empty, almost_full, full, empty, overflow, exp_cnt);
      end
    end
    push = 1'b0;
  endtask

  task automatic test_overflow();
    push = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_write got %0b exp 0", write);
    end
    tick();
    push = 1'b0;
    checks++;
    if (ptr_write !== 3'd0 || count !== 4'd8 || overflow !== 1'b1 || full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_state got pw=%0d cnt=%0d ov=%0b f=%0b exp pw=0 cnt=8 ov=1 f=1", ptr_write, count, overflow, full);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (overflow !== 1'b1 || count !== 4'd8) begin
        failures++;
        $display("[TB] FAIL ovf_sticky[%0d] got ov=%0b cnt=%0d exp ov=1 cnt=8", i, overflow, count);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push = 1'b1;
      data_in = 10'(i + 1);
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      push = 1'b1; pop = 1'b1;
      data_in = 10'(k + 3);
      #1;
      checks++;
      if (write !== 1'b1 || read !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_strobes[%0d] got wr=%0b rd=%0b exp 1 1", k, write, read);
      end
      tick();
      checks++;
      if (count !== 4'd2 || ptr_write !== 3'((k + 3) % 8) || ptr_read !== 3'((k + 1) % 8)) begin
        failures++;
        $display("[TB] FAIL b2b_ptrs[%0d] got cnt=%0d pw=%0d pr=%0d exp cnt=2 pw=%0d pr=%0d", k, count, ptr_write, ptr_read, (k + 3) % 8, (k + 1) % 8);
      end
      checks++;
      if (rd_valid !== 1'b1 || data_out !== 10'(k + 1)) begin
        failures++;
        $display("[TB] FAIL b2b_data[%0d] got rv=%0b dout=%0d exp rv=1 dout=%0d", k, rd_valid, data_out, k + 1);
      end
    end
    push = 1'b0; pop = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || count !== 4'd2) begin
      failures++;
      $display("[TB] FAIL b2b_idle got rv=%0b cnt=%0d exp rv=0 cnt=2", rd_valid, count);
    end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    tick();
    tick();
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || ptr_read !== 3'd6 || underflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unf_drain got e=%0b cnt=%0d pr=%0d un=%0b exp e=1 cnt=0 pr=6 un=0", empty, count, ptr_read, underflow);
    end
    #1;
    checks++;
    if (read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unf_read got %0b exp 0", read);
    end
    tick();
    checks++;
    if (underflow !== 1'b1 || ptr_read !== 3'd6 || count !== 4'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unf_flag got un=%0b pr=%0d cnt=%0d rv=%0b exp un=1 pr=6 cnt=0 rv=0", underflow, ptr_read, count, rd_valid);
    end
    push = 1'b1;
    #1;
    checks++;
    if (write !== 1'b1 || read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unf_both_strobes got wr=%0b rd=%0b exp wr=1 rd=0", write, read);
    end
    tick();
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 4'd1 || rd_valid !== 1'b0 || empty !== 1'b0 || underflow !== 1'b1 || ptr_write !== 3'd7) begin
      failures++;
      $display("[TB] FAIL unf_both got cnt=%0d rv=%0b e=%0b un=%0b pw=%0d exp cnt=1 rv=0 e=0 un=1 pw=7", count, rd_valid, empty, underflow, ptr_write);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    push = 1'b0;
    checks++;
    if (count !== 4'd5 || ptr_write !== 3'd5) begin
      failures++;
      $display("[TB] FAIL arst_pre got cnt=%0d pw=%0d exp cnt=5 pw=5", count, ptr_write);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || ptr_write !== 3'd0 || ptr_read !== 3'd0 || almost_empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arst_clear got cnt=%0d e=%0b pw=%0d pr=%0d ae=%0b exp 0 1 0 0 1", count, empty, ptr_write, ptr_read, almost_empty);
    end
    tick();
    reset = 1'b1;
    push = 1'b1;
    data_in = 10'h155;
    #1;
    checks++;
    if (write !== 1'b1 || ptr_write !== 3'd0) begin
      failures++;
      $display("[TB] FAIL arst_first_push got wr=%0b pw=%0d exp wr=1 pw=0", write, ptr_write);
    end
    tick();
    push = 1'b0;
    checks++;
    if (count !== 4'd1 || ptr_write !== 3'd1 || mem[0] !== 10'h155) begin
      failures++;
      $display("[TB] FAIL arst_after got cnt=%0d pw=%0d mem0=%0h exp cnt=1 pw=1 mem0=155", count, ptr_write, mem[0]);
    end
  endtask

  task automatic test_length6();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push6 = 1'b1;
      tick();
      checks++;
      if (ptr_write6 !== 3'((i + 1) % 6) || count6 !== 4'(i + 1) || full6 !== (i == 5)) begin
        failures++;
        $display("[TB] FAIL len6_push[%0d] got pw=%0d cnt=%0d f=%0b exp pw=%0d cnt=%0d f=%0b", i, ptr_write6, count6, full6, (i + 1) % 6, i + 1, i == 5);
      end
    end
    push6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pop6 = 1'b1;
      tick();
      checks++;
      if (ptr_read6 !== 3'((i + 1) % 6) || count6 !== 4'(5 - i) || empty6 !== (i == 5)) begin
        failures++;
        $display("[TB] FAIL len6_pop[%0d] got pr=%0d cnt=%0d e=%0b exp pr=%0d cnt=%0d e=%0b", i, ptr_read6, count6, empty6, (i + 1) % 6, 5 - i, i == 5);
      end
    end
    pop6 = 1'b0;
    checks++;
    if (overflow6 !== 1'b0 || underflow6 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL len6_errs got ov=%0b un=%0b exp 0 0", overflow6, underflow6);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_async_reset();
    test_length6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequencing controller for the dual-pointer memory: clk, reset, read, write, ptr_read[2:0], ptr_write[2:0], and BITNUMBER-wide data_in/data_out.
- Turns a push/pop requester interface into memory write/read strobes and pointers.
- Tracks occupancy and exposes full/empty/almost flags plus sticky error flags.
- Data bypasses the block; only control and pointers are generated here.

Parameters:
- LENGTH, 8, memory depth in words; any value 2..2**PTR_WIDTH, power of two not required.
- PTR_WIDTH, 3, pointer width; must satisfy 2**PTR_WIDTH >= LENGTH.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  requester writes one word this cycle.
- pop  input  1  requester reads one word this cycle.
- write  output  1  memory write strobe.
- ptr_write  output  PTR_WIDTH  memory write address.
- read  output  1  memory read strobe.
- ptr_read  output  PTR_WIDTH  memory read address.
- rd_valid  output  1  memory data_out holds the popped word this cycle.
- count  output  PTR_WIDTH+1  occupancy, 0..LENGTH.
- full  output  1  count == LENGTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset==0, asynchronous, any cycle, including mid-stream):
  - ptr_write=0, ptr_read=0, count=0, rd_valid=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Released on the first posedge after reset returns to 1.
- Acceptance (combinational from registered flags):
  - push_ok = push & ~full; pop_ok = pop & ~empty.
  - write = push_ok; read = pop_ok.
  - ptr_write/ptr_read are registered and present the current slot, so strobe and address are valid in the same cycle.
- On posedge:
  - push_ok: ptr_write advances; LENGTH-1 wraps to 0 by explicit compare, not by truncation.
  - pop_ok: ptr_read advances with the same wrap rule.
  - count += push_ok - pop_ok. push_ok & pop_ok leaves count unchanged; both pointers still advance.
  - All four flags are registered from the next count value, so they are valid the cycle after the change, with no extra lag.
- rd_valid: registered copy of pop_ok, giving one-cycle read latency to match the registered memory output.
- Boundary rules:
  - Full with push & pop: pop accepted, push rejected (write=0), count = LENGTH-1, overflow set.
  - Empty with push & pop: push accepted, pop rejected (read=0), count=1, underflow set. No same-cycle bypass.
  - Rejected requests change no pointer and no count.
- overflow/underflow hold at 1 until reset.
- Invariant: count == (ptr_write - ptr_read) mod LENGTH, except count==LENGTH when the pointers are equal and full==1.
- Idle (push=pop=0): all state holds; read=write=0.

Decomposition:
- Shared include fifo_defs.vh: default LENGTH, PTR_WIDTH, BITNUMBER (10), and threshold defaults, reused by the memory, this controller and the probador-style benches.
- One natural sub-module, fifo_ptr: wrap-around pointer register with clk, reset, inc, and a LENGTH parameter. Instantiated twice, for write and read.
- Flags and count stay in fifo_ctrl.

Test Plan:
- Reset, then 8 pushes on consecutive cycles:
  - ptr_write steps 1..7 then wraps to 0; count ends at 8.
  - Flags over time: almost_empty clears when count=3, almost_full sets when count=6, full=1 after the 8th push.
  - overflow stays 0.
- From full, push alone:
  - write=0, ptr_write and count unchanged, overflow=1 and stays 1 through 5 idle cycles.
- Push and pop every cycle for 12 cycles starting at count=2:
  - count stays 2; both pointers wrap 7->0.
  - rd_valid=1 each cycle after the first pop.
  - Data words 1..12 come out in order at data_out.
- From empty, pop alone, then push and pop together:
  - First cycle: read=0, underflow=1.
  - Second cycle: only write=1; count=1; rd_valid stays 0.
- Assert reset low mid-stream at count=5 asynchronously between edges:
  - Outputs clear immediately: count=0, empty=1, pointers=0.
  - First push after release writes to address 0.
- With LENGTH=6, PTR_WIDTH=3:
  - 6 pushes then 6 pops: pointers wrap 5->0, never reach 6 or 7.
  - full after 6 pushes, empty after 6 pops.
